// File: rtl/cam_capture_if.sv
// Pixel stream interface: FIFO head towards the consumer.
// The master drives the head pixel; the slave accepts it with out_ready.
interface cam_capture_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sof;
    logic        out_eol;

    modport master (
        output out_valid,
        output out_data,
        output out_sof,
        output out_eol,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eol,
        output out_ready
    );
endinterface

// File: rtl/cam_capture.sv
// Camera capture: assembles 8-bit camera bytes into 16-bit pixels, tags start-of-frame
// and end-of-line, and buffers them in a small output FIFO.
// Optional feature: define CAM_CAPTURE_TESTPAT_EN to replace cam_data with an
// internal {y[3:0], x[3:0]} pattern that follows the camera timing.
module cam_capture #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned XW         = 11,
    parameter int unsigned YW         = 10
) (
    input  logic          cam_clk,
    input  logic          cam_reset_n,
    input  logic          capture_en,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    cam_capture_if.master out_if,
    output logic          overflow,
    output logic [7:0]    frame_cnt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DepthC = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWaitVs, StActive, StDrop} state_e;

    state_e state_q, state_d;
    logic   capturing, active;

    logic          vs_q, href_q;
    logic          vs_rise, vs_fall, href_fall;
    logic          phase_q;
    logic [7:0]    hi_q;
    logic [7:0]    byte_in;
    logic          pix_done;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Two-stage pixel pipeline: s1 holds the fresh pixel, s2 waits one more href sample
    // so a trailing dangling byte does not hide the end of line.
    logic        s1_valid_q, s1_sof_q;
    logic [15:0] s1_data_q;
    logic        s2_valid_q, s2_sof_q, s2_href_q;
    logic [15:0] s2_data_q;

    logic        wr_req, push, pop, drop, full, empty;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [17:0] head;

    logic       overflow_q;
    logic [7:0] frame_cnt_q;

    assign vs_rise   = cam_vsync & ~vs_q;
    assign vs_fall   = ~cam_vsync & vs_q;
    assign href_fall = href_q & ~cam_href;

`ifdef CAM_CAPTURE_TESTPAT_EN
    assign byte_in = {y_q[3:0], x_q[3:0]};
`else
    assign byte_in = cam_data;
`endif

    // FSM state register
    always_ff @(posedge cam_clk or negedge cam_reset_n) begin
        if (!cam_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (capture_en) state_d = StWaitVs;
            StWaitVs: if (vs_fall) state_d = StActive;
            StActive: begin
                if (vs_rise) begin
                    state_d = capture_en ? StWaitVs : StIdle;
                end else if (drop) begin
                    state_d = StDrop;
                end
            end
            StDrop:   if (vs_rise) state_d = capture_en ? StWaitVs : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: byte assembly runs in ACTIVE and DROP, FIFO writes only in ACTIVE
    always_comb begin
        capturing = 1'b0;
        active    = 1'b0;
        unique case (state_q)
            StActive: begin
                capturing = 1'b1;
                active    = 1'b1;
            end
            StDrop:   capturing = 1'b1;
            default:  ;
        endcase
    end

    assign pix_done = capturing & cam_href & phase_q;

    // Sync edge history, byte phase and high-byte latch
    always_ff @(posedge cam_clk or negedge cam_reset_n) begin
        if (!cam_reset_n) begin
            vs_q    <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
        end else begin
            vs_q    <= cam_vsync;
            href_q  <= cam_href;
            phase_q <= (capturing && cam_href) ? ~phase_q : 1'b0;
            if (capturing && cam_href && !phase_q) begin
                hi_q <= byte_in;
            end
        end
    end

    // Pixel position counters, saturating; x advances when a pixel leaves s1
    always_ff @(posedge cam_clk or negedge cam_reset_n) begin
        if (!cam_reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (cam_vsync || href_fall) begin
                x_q <= '0;
            end else if (s1_valid_q && active && x_q != '1) begin
                x_q <= x_q + 1'b1;
            end
            if (cam_vsync) begin
                y_q <= '0;
            end else if (href_fall && y_q != '1) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    // Pixel pipeline; eol is known once href has been seen low in either of the
    // two cycles after the pixel completed
    always_ff @(posedge cam_clk or negedge cam_reset_n) begin
        if (!cam_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_data_q  <= 16'h0000;
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_href_q  <= 1'b0;
            s2_data_q  <= 16'h0000;
        end else begin
            s1_valid_q <= pix_done & active;
            if (pix_done) begin
                s1_data_q <= {hi_q, byte_in};
                s1_sof_q  <= (x_q == '0) && (y_q == '0);
            end
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s1_data_q;
            s2_sof_q   <= s1_sof_q;
            s2_href_q  <= cam_href;
        end
    end

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = ((wr_ptr_q - rd_ptr_q) == DepthC);
    assign pop    = ~empty & out_if.out_ready;
    assign wr_req = s2_valid_q & active;
    assign push   = wr_req & (~full | pop);
    assign drop   = wr_req & full & ~pop;

    // FIFO pointers
    always_ff @(posedge cam_clk or negedge cam_reset_n) begin
        if (!cam_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage: {sof, eol, data}
    always_ff @(posedge cam_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s2_sof_q, ~(s2_href_q & cam_href), s2_data_q};
        end
    end

    assign head             = empty ? 18'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign out_if.out_valid = ~empty;
    assign out_if.out_sof   = head[17];
    assign out_if.out_eol   = head[16];
    assign out_if.out_data  = head[15:0];

    // Sticky overflow and completed-frame counter
    always_ff @(posedge cam_clk or negedge cam_reset_n) begin
        if (!cam_reset_n) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            if (state_q == StIdle && state_d != StIdle) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
            if (active && vs_rise) begin
                frame_cnt_q <= frame_cnt_q + 8'h01;
            end
        end
    end

    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, at least 2).
REQ-002 Parameter XW, default 11, meaning pixel-column counter width.
REQ-003 Parameter YW, default 10, meaning line counter width.
REQ-004 cam_clk  input  1  single clock, the camera clock; all logic on its rising edge.
REQ-005 cam_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 capture_en  input  1  level; arms capture at the next frame boundary.
REQ-007 cam_vsync  input  1  frame sync; high = vertical blanking.
REQ-008 cam_href  input  1  line valid; bytes are valid while high.
REQ-009 cam_data  input  8  camera byte bus.
REQ-010 out_valid  output  1  FIFO head valid.
REQ-011 out_ready  input  1  consumer accept.
REQ-012 out_data  output  16  pixel, first byte in [15:8], second byte in [7:0].
REQ-013 out_sof  output  1  head pixel is x=0, y=0 of the frame.
REQ-014 out_eol  output  1  head pixel is the last pixel of its line.
REQ-015 overflow  output  1  sticky; a pixel was dropped.
REQ-016 frame_cnt  output  8  completed frames, wraps at 255->0.

Function
REQ-017 FSM states: IDLE, WAIT_VS, ACTIVE, DROP.
REQ-018 IDLE -> WAIT_VS when capture_en=1.
REQ-019 WAIT_VS -> ACTIVE on the first cycle where cam_vsync is low and was high the cycle before (registered falling edge).
REQ-020 ACTIVE -> DROP when a pixel completes while the FIFO is full.
REQ-021 ACTIVE or DROP -> WAIT_VS on a vsync rising edge if capture_en=1; otherwise -> IDLE.
REQ-022 frame_cnt increments on the vsync rising edge when leaving ACTIVE only; leaving DROP does not increment it.
REQ-023 In ACTIVE with href=1, byte phase toggles every cycle; even phase latches the high byte; odd phase completes the pixel and pushes it.
REQ-024 Byte phase clears when href=0; an odd byte count leaves a dangling byte, which is discarded.
REQ-025 x counter increments per pushed pixel and clears on the href falling edge; y increments on the href falling edge and clears on vsync.
REQ-026 out_sof is set for the pixel with x=0, y=0.
REQ-027 out_eol is attached to the last pushed pixel of a line: each pixel is held one cycle and eol is resolved from href before the pixel is written, so data latency from the second byte to FIFO write is 2 cycles.
REQ-028 x and y saturate at all-ones and do not wrap.
REQ-029 FIFO pops on out_valid and out_ready; push and pop in the same cycle while full is allowed and is not an overflow.
REQ-030 In DROP, pixels are discarded and the FIFO still drains.
REQ-031 Dropping capture_en mid-frame takes effect at the next vsync rising edge.

Reset
REQ-032 Asynchronous reset drives state=IDLE, FIFO empty, out_valid=0, out_data=0, out_sof=0, out_eol=0, overflow=0, frame_cnt=0, and clears all counters and the byte phase.
REQ-033 overflow clears only on reset or on a transition out of IDLE.

Configuration
REQ-034 Macro CAM_CAPTURE_TESTPAT_EN.
REQ-035 When defined, cam_data is replaced internally by {y[3:0], x[3:0]} of the current byte position, keeping the camera timing; this gives a deterministic pattern.
REQ-036 When not defined, cam_data is used directly and no test-pattern logic exists.

Verification
REQ-037 Reset mid-ACTIVE -> all outputs return to their reset values immediately; frame_cnt=0.
REQ-038 Frame of 2 lines x 4 bytes, bytes 0x12,0x34,0x56,0x78, out_ready=1 -> pixels 0x1234 (sof=1), 0x5678 (eol=1); line 2 the same with sof=0; frame_cnt=1 after vsync rises.
REQ-039 out_ready=0, 12-byte line -> 4 pixels held in the FIFO, the 5th is dropped; overflow=1 and state=DROP; the next frame is not counted and capture resumes at the following vsync.
REQ-040 Line of 5 bytes -> 2 pixels, the last byte is discarded, eol on the 2nd pixel.
REQ-041 capture_en falls mid-frame -> the current frame completes and counts, then the FSM goes to IDLE; a following frame produces no output.
REQ-042 With CAM_CAPTURE_TESTPAT_EN defined, line 1 byte 0 and byte 1 -> out_data=0x0000 for pixel 0; the second pixel of line 1 is 0x0001 in the x nibble sequence.
